gyruss_sndcmd: RTL and testbench
================================

# gyruss_sndcmd

Sound-command mailbox between the main CPU board and the sound CPU. Captures the command byte written by the main Z80 when it issues a sound request. Raises and holds the sound-CPU interrupt until acknowledged, and presents the command on a read port. Sits directly downstream of the main board's SNDNO/SNDRQ outputs, in the MCLK domain, upstream of the sound CPU data bus selector.

## Interface
Parameters:
- FIFO_AW, 2, log2 of queue depth; used only when the FIFO is compiled in.

Ports:
- MCLK  in  1  master clock; all logic clocked on its rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- SNDRQ  in  1  sound request from main board; a level that stays high for the whole main-CPU write cycle (several MCLK).
- SNDNO  in  8  command byte from main board; stable before SNDRQ rises.
- SCPU_IACK  in  1  sound CPU interrupt acknowledge, level.
- SCPU_RD  in  1  sound CPU read strobe of the command port, level.
- SCPU_DO  out  8  command byte to the sound CPU data selector.
- SCPU_IRQ  out  1  interrupt request to the sound CPU, active-high.
- PEND  out  3  number of stored, unread commands (0..depth).
- OVF  out  1  sticky overflow flag.

## Operation
- Input stage:
  - r1 <= SNDRQ, r2 <= r1.
  - push = r1 & ~r2. SNDNO is captured on the push edge.
  - A request held high produces exactly one push.
- Read stage:
  - rd_q <= SCPU_RD.
  - pop = ~SCPU_RD & rd_q, i.e. on the falling edge, so data stays stable while the read is asserted.
  - pop is ignored when PEND = 0.
- IACK stage:
  - ia_q <= SCPU_IACK.
  - ack = SCPU_IACK & ~ia_q.
- IRQ state machine, states IDLE, REQ, SERV:
  - IDLE -> REQ when PEND ≠ 0.
  - REQ -> SERV on ack.
  - SERV -> IDLE on pop.
  - SCPU_IRQ = (state == REQ).
  - ack in IDLE or SERV is ignored.
  - pop in REQ removes the entry and keeps IRQ asserted only if PEND stays ≠ 0; otherwise the state moves to IDLE.
- SCPU_DO:
  - When PEND ≠ 0, it shows the head entry.
  - When PEND = 0, it shows the last value that was the head (00h after reset).
- OVF is set on a push that finds storage full with no simultaneous pop. It clears only on RESET.
- Simultaneous push and pop: the pop removes the head, then the push appends. PEND is unchanged and OVF is not set.
- Reset values: SCPU_IRQ 0, SCPU_DO 00h, PEND 0, OVF 0, state IDLE, all pointers and storage 0.
- RESET asserted mid-operation clears everything immediately, with no clock required.

## Timing
- The first MCLK edge that samples SNDRQ = 1 is edge k.
- The push commits at edge k+1: PEND and SCPU_DO update after k+1.
- SCPU_IRQ rises after edge k+2.
- SCPU_IRQ falls after the first edge that samples SCPU_IACK = 1.
- A pop commits at the first edge that samples SCPU_RD = 0 after it was 1. PEND and SCPU_DO update after that edge.
- In FIFO mode with entries remaining, IRQ re-asserts one edge after the pop (SERV -> IDLE -> REQ).
- Minimum spacing between pushes is 2 MCLK, set by SNDRQ low time. The main board guarantees at least 16.

## Configuration
- GYRUSS_SNDCMD_FIFO_EN defined:
  - Storage is a 2^FIFO_AW-entry queue.
  - A push while full is dropped and sets OVF.
  - The sound CPU reads commands in order.
- GYRUSS_SNDCMD_FIFO_EN undefined (hardware-faithful default):
  - Single 8-bit latch; depth is 1 and PEND is 0 or 1.
  - A push while full overwrites the latch, sets OVF, and leaves the FSM state unchanged.
  - FIFO_AW is unused.

## Test plan
- Reset: assert RESET without clock -> SCPU_IRQ 0, SCPU_DO 00h, PEND 0, OVF 0. Release, idle 20 MCLK -> all unchanged.
- Basic request (both configurations):
  - Stimulus: SNDNO = 5Ah, SNDRQ high for 16 MCLK.
  - Required: PEND 1 and SCPU_DO 5Ah after edge k+1; SCPU_IRQ 1 after k+2; exactly one push.
  - Then pulse SCPU_IACK for 4 MCLK -> IRQ 0 after the first sampling edge.
  - Then pulse SCPU_RD for 4 MCLK -> PEND 0, SCPU_DO stays 5Ah, IRQ stays 0.
- Overwrite (macro off): push 11h then 22h without a read -> SCPU_DO 22h, PEND 1, OVF 1, IRQ 1.
- FIFO (macro on, FIFO_AW = 2):
  - Stimulus: push 01h..05h.
  - Required: PEND 4 and OVF 1.
  - Four IACK/RD pairs return 01h, 02h, 03h, 04h.
  - IRQ re-asserts one edge after each of the first three pops; IRQ is 0 and PEND is 0 after the fourth.
- Simultaneous push and pop: time the SNDRQ rise so the push and the RD falling edge hit the same edge with PEND = 1 -> PEND 1, new byte at head, OVF 0 (both configurations).
- Reset mid-operation: assert RESET while in REQ with PEND 3 -> IRQ 0 and PEND 0 before the next MCLK edge. After release, no IRQ until a new push.

Source files
------------

// File: rtl/gyruss_sndcmd_if.sv
// Sound-command mailbox bus between the main board, the mailbox and the
// sound CPU.
//   master : main board / sound CPU side (drives requests, strobes)
//   slave  : gyruss_sndcmd (drives command byte, IRQ and status)
// Signals:
//   SNDRQ     sound request level from the main board
//   SNDNO     command byte from the main board
//   SCPU_IACK sound CPU interrupt acknowledge (level)
//   SCPU_RD   sound CPU read strobe of the command port (level)
//   SCPU_DO   command byte presented to the sound CPU data selector
//   SCPU_IRQ  interrupt request to the sound CPU, active-high
//   PEND      number of stored, unread commands
//   OVF       sticky overflow flag
interface gyruss_sndcmd_if;
  logic       SNDRQ;
  logic [7:0] SNDNO;
  logic       SCPU_IACK;
  logic       SCPU_RD;
  logic [7:0] SCPU_DO;
  logic       SCPU_IRQ;
  logic [2:0] PEND;
  logic       OVF;

  modport master (
    output SNDRQ, SNDNO, SCPU_IACK, SCPU_RD,
    input  SCPU_DO, SCPU_IRQ, PEND, OVF
  );

  modport slave (
    input  SNDRQ, SNDNO, SCPU_IACK, SCPU_RD,
    output SCPU_DO, SCPU_IRQ, PEND, OVF
  );
endinterface

// File: rtl/gyruss_sndcmd.sv
// Sound-command mailbox from the main CPU board to the sound CPU.
// Captures SNDNO on the rising edge of SNDRQ, raises SCPU_IRQ until the
// sound CPU acknowledges, and presents the head command on SCPU_DO until
// the sound CPU finishes reading it (falling edge of SCPU_RD).
// Ports:
//   MCLK  master clock, rising edge
//   RESET asynchronous, active-high reset
//   bus   gyruss_sndcmd_if.slave (SNDRQ/SNDNO in, SCPU_IACK/SCPU_RD in,
//         SCPU_DO/SCPU_IRQ/PEND/OVF out)
// Build option:
//   GYRUSS_SNDCMD_FIFO_EN  defined   -> 2^FIFO_AW-entry queue, full push dropped
//                          undefined -> single latch, full push overwrites
// FIFO_AW is limited to 1..2 so that PEND (3 bits) can hold the full depth.
module gyruss_sndcmd #(
  parameter int FIFO_AW = 2
) (
  input logic            MCLK,
  input logic            RESET,
  gyruss_sndcmd_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  if ((FIFO_AW < 1) || (FIFO_AW > 2)) begin : g_aw_check
    $error("gyruss_sndcmd: FIFO_AW must be 1 or 2");
  end

  state_t     state_r, state_s;
  logic       irq_r;
  logic       r1_r, r2_r, rd_q_r, ia_q_r;
  logic       push_s, pop_s, ack_s, full_s;
  logic [2:0] pend_r, pend_s;
  logic       ovf_r, ovf_s;
  logic [7:0] do_r, do_s;

  assign push_s = r1_r & ~r2_r;
  // A read strobe with nothing stored must not move pointers or the FSM.
  assign pop_s  = ~bus.SCPU_RD & rd_q_r & (pend_r != 3'd0);
  assign ack_s  = bus.SCPU_IACK & ~ia_q_r;

  // Input synchronisers and edge-detect history for SNDRQ, SCPU_RD, SCPU_IACK.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r1_r   <= 1'b0;
      r2_r   <= 1'b0;
      rd_q_r <= 1'b0;
      ia_q_r <= 1'b0;
    end else begin
      r1_r   <= bus.SNDRQ;
      r2_r   <= r1_r;
      rd_q_r <= bus.SCPU_RD;
      ia_q_r <= bus.SCPU_IACK;
    end
  end

`ifdef GYRUSS_SNDCMD_FIFO_EN
  localparam int DEPTH_P = 32'd1 << FIFO_AW;

  logic [7:0]         mem_r [0:DEPTH_P-1];
  logic [FIFO_AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_s;
  logic               wr_en_s;

  assign full_s  = (pend_r == 3'(DEPTH_P));
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en_s = push_s & (~full_s | pop_s);

  // Queue bookkeeping: next count, overflow and next head byte.
  always_comb begin
    pend_s   = pend_r;
    ovf_s    = ovf_r;
    do_s     = do_r;
    rd_ptr_s = rd_ptr_r;
    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + FIFO_AW'(1'b1);
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    case ({wr_en_s, pop_s})
      2'b10:   pend_s = pend_r + 3'd1;
      2'b01:   pend_s = pend_r - 3'd1;
      default: pend_s = pend_r;
    endcase
    if (push_s & full_s & ~pop_s) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = ovf_r;
    end
    // The new head is the byte being written only when the queue would
    // otherwise be empty after the pop; an empty queue keeps the old head.
    if (pend_s != 3'd0) begin
      if (wr_en_s && (wr_ptr_r == rd_ptr_s)) begin
        do_s = bus.SNDNO;
      end else begin
        do_s = mem_r[rd_ptr_s];
      end
    end else begin
      do_s = do_r;
    end
  end

  // Queue storage and pointers.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      for (int i = 0; i < DEPTH_P; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      rd_ptr_r <= rd_ptr_s;
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= bus.SNDNO;
        wr_ptr_r        <= wr_ptr_r + FIFO_AW'(1'b1);
      end
    end
  end
`else
  assign full_s = (pend_r != 3'd0);

  // Single latch: do_r is the latch itself, a push always overwrites it.
  always_comb begin
    pend_s = pend_r;
    ovf_s  = ovf_r;
    do_s   = do_r;
    if (push_s) begin
      pend_s = 3'd1;
      do_s   = bus.SNDNO;
    end else if (pop_s) begin
      pend_s = 3'd0;
    end else begin
      pend_s = pend_r;
    end
    if (push_s & full_s & ~pop_s) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = ovf_r;
    end
  end
`endif

  // IRQ state machine next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pend_r != 3'd0) state_s = REQ;
        else                state_s = IDLE;
      end
      REQ: begin
        if (pop_s && (pend_s == 3'd0)) state_s = IDLE;
        else if (ack_s)                state_s = SERV;
        else                           state_s = REQ;
      end
      SERV: begin
        if (pop_s) state_s = IDLE;
        else       state_s = SERV;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, status and registered output flops.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
      irq_r   <= 1'b0;
      pend_r  <= 3'd0;
      ovf_r   <= 1'b0;
      do_r    <= 8'h00;
    end else begin
      state_r <= state_s;
      irq_r   <= (state_s == REQ);
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
      do_r    <= do_s;
    end
  end

  assign bus.SCPU_IRQ = irq_r;
  assign bus.SCPU_DO  = do_r;
  assign bus.PEND     = pend_r;
  assign bus.OVF      = ovf_r;

endmodule

// File: tb/tb_gyruss_sndcmd.sv
// Table-driven bench for gyruss_sndcmd. Each record holds the inputs for
// one or more MCLK cycles and the outputs expected after each of those
// edges. Expected values are hand-derived from the mailbox timing.
module tb_gyruss_sndcmd;

  typedef struct {
    logic       rst;
    logic       rq;
    logic [7:0] no;
    logic       iack;
    logic       rd;
    int         reps;
    logic       irq;
    logic [7:0] dout;
    logic [2:0] pend;
    logic       ovf;
  } vec_t;

  logic MCLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vec_q[$];

  gyruss_sndcmd_if sc_if();

  gyruss_sndcmd #(.FIFO_AW(2)) dut (
    .MCLK (MCLK),
    .RESET(RESET),
    .bus  (sc_if)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s (vec %0d): got %02h, expected %02h", nm, idx, act, exp_v);
    end
  endtask

  task automatic chk_all(input int idx, input logic irq, input logic [7:0] dout,
                         input logic [2:0] pend, input logic ovf);
    chk("irq",  idx, {7'd0, sc_if.SCPU_IRQ}, {7'd0, irq});
    chk("do",   idx, sc_if.SCPU_DO, dout);
    chk("pend", idx, {5'd0, sc_if.PEND}, {5'd0, pend});
    chk("ovf",  idx, {7'd0, sc_if.OVF}, {7'd0, ovf});
  endtask

  task automatic add(input logic rst, input logic rq, input logic [7:0] no, input logic iack,
                     input logic rd, input int reps, input logic irq, input logic [7:0] dout,
                     input logic [2:0] pend, input logic ovf);
    vec_t v;
    v.rst = rst; v.rq = rq; v.no = no; v.iack = iack; v.rd = rd; v.reps = reps;
    v.irq = irq; v.dout = dout; v.pend = pend; v.ovf = ovf;
    vec_q.push_back(v);
  endtask

  task automatic drive(input logic rq, input logic [7:0] no, input logic iack, input logic rd);
    sc_if.SNDRQ = rq; sc_if.SNDNO = no; sc_if.SCPU_IACK = iack; sc_if.SCPU_RD = rd;
  endtask

  initial begin
    int n_push;
    // ---------------- table fill ----------------
    // Idle after reset release: everything stays at reset values.
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 20, 1'b0, 8'h00, 3'd0, 1'b0);
    // Basic request 5Ah, SNDRQ high 16 cycles: edge k, k+1 (push), k+2 (IRQ).
    add(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1,  1'b0, 8'h00, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1,  1'b0, 8'h5A, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 14, 1'b1, 8'h5A, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 3,  1'b1, 8'h5A, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 4,  1'b0, 8'h5A, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 2,  1'b0, 8'h5A, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 4,  1'b0, 8'h5A, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1,  1'b0, 8'h5A, 3'd0, 1'b0);
    add(1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 3,  1'b0, 8'h5A, 3'd0, 1'b0);
    // Second push 11h then 22h with no read in between.
    add(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1,  1'b0, 8'h5A, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1,  1'b0, 8'h11, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 15, 1'b1, 8'h11, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1,  1'b1, 8'h11, 3'd1, 1'b0);
`ifdef GYRUSS_SNDCMD_FIFO_EN
    add(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1,  1'b1, 8'h11, 3'd2, 1'b0);
    add(1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 3,  1'b1, 8'h11, 3'd2, 1'b0);
`else
    add(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1,  1'b1, 8'h22, 3'd1, 1'b1);
    add(1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 3,  1'b1, 8'h22, 3'd1, 1'b1);
`endif
    // Synchronous-cycle reset back to the initial state.
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2,  1'b0, 8'h00, 3'd0, 1'b0);
    // Simultaneous push (BBh) and pop with PEND = 1.
    add(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1,  1'b0, 8'h00, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1,  1'b0, 8'hAA, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 2,  1'b1, 8'hAA, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 1,  1'b0, 8'hAA, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1,  1'b0, 8'hAA, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'hBB, 1'b0, 1'b1, 1,  1'b0, 8'hAA, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1, 1,  1'b0, 8'hAA, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1,  1'b0, 8'hBB, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1,  1'b1, 8'hBB, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'hBB, 1'b0, 1'b0, 3,  1'b1, 8'hBB, 3'd1, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2,  1'b0, 8'h00, 3'd0, 1'b0);
`ifdef GYRUSS_SNDCMD_FIFO_EN
    // Push 01h..05h into a 4-deep queue: fifth push overflows.
    for (int j = 1; j <= 5; j++) begin
      add(1'b0, 1'b1, 8'(j), 1'b0, 1'b0, 1, (j > 1), (j > 1) ? 8'h01 : 8'h00,
          3'((j > 4) ? 4 : j - 1), 1'b0);
      add(1'b0, 1'b1, 8'(j), 1'b0, 1'b0, 1, (j > 1), 8'h01,
          3'((j > 4) ? 4 : j), (j == 5));
      add(1'b0, 1'b0, 8'(j), 1'b0, 1'b0, 2, 1'b1, 8'h01,
          3'((j > 4) ? 4 : j), (j == 5));
    end
    // Four IACK/RD pairs drain the queue in order.
    for (int j = 1; j <= 4; j++) begin
      add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'(j), 3'(5 - j), 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 8'(j), 3'(5 - j), 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'(j), 3'(5 - j), 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 8'((j < 4) ? j + 1 : 4), 3'(4 - j), 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2, (j < 4), 8'((j < 4) ? j + 1 : 4), 3'(4 - j), 1'b1);
    end
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2,  1'b0, 8'h00, 3'd0, 1'b0);
`endif

    // ---------------- reset without a clock edge ----------------
    RESET = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk_all(-1, 1'b0, 8'h00, 3'd0, 1'b0);
    @(posedge MCLK); #1;
    RESET = 1'b0;

    // ---------------- table application ----------------
    for (int i = 0; i < vec_q.size(); i++) begin
      for (int r = 0; r < vec_q[i].reps; r++) begin
        RESET = vec_q[i].rst;
        drive(vec_q[i].rq, vec_q[i].no, vec_q[i].iack, vec_q[i].rd);
        @(posedge MCLK); #1;
        chk_all(i, vec_q[i].irq, vec_q[i].dout, vec_q[i].pend, vec_q[i].ovf);
      end
    end
    RESET = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge MCLK);
    #1;

    // ---------------- reset mid-operation while in REQ ----------------
`ifdef GYRUSS_SNDCMD_FIFO_EN
    n_push = 3;
`else
    n_push = 1;
`endif
    for (int j = 0; j < n_push; j++) begin
      drive(1'b1, 8'h30 + 8'(j), 1'b0, 1'b0);
      repeat (2) @(posedge MCLK);
      #1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) @(posedge MCLK);
      #1;
    end
    chk("mid_irq_before",  -2, {7'd0, sc_if.SCPU_IRQ}, 8'h01);
    chk("mid_pend_before", -2, {5'd0, sc_if.PEND}, 8'(n_push));
    @(negedge MCLK);
    RESET = 1'b1;
    #1;
    chk_all(-3, 1'b0, 8'h00, 3'd0, 1'b0);
    #2;
    RESET = 1'b0;
    repeat (10) @(posedge MCLK);
    #1;
    chk("mid_irq_after",  -4, {7'd0, sc_if.SCPU_IRQ}, 8'h00);
    chk("mid_pend_after", -4, {5'd0, sc_if.PEND}, 8'h00);
    // A fresh push raises IRQ again after edge k+2.
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    repeat (3) @(posedge MCLK);
    #1;
    chk_all(-5, 1'b1, 8'h77, 3'd1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
